// File: rtl/countdown_8bits.sv
// Prescaled 8-bit down counter with load, start/pause control and a Done state.
// Q steps down once every PRESCALE clock edges while running; Tick marks each step.
module countdown_8bits #(
  parameter int unsigned PRESCALE = 50000000
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Load,
  input  logic [7:0] D,
  input  logic       Start,
  input  logic       Pause,
  output logic [7:0] Q,
  output logic       Tick,
  output logic       Running,
  output logic       Done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [25:0] PRESC_MAX = 26'(PRESCALE - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [25:0] presc_q, presc_d;
  logic        tick_q,  tick_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (Load) begin
      count_d = D;
      presc_d = '0;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Pause outranks Start, so a simultaneous request stays idle
          if (Start && !Pause) begin
            state_d = (count_q != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (Pause) begin
            state_d = S_PAUSED;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (count_q != '0) begin
              count_d = count_q - 8'd1;
              tick_d  = 1'b1;
            end
            if (count_q <= 8'd1) begin
              state_d = S_DONE;
            end
          end else begin
            presc_d = presc_q + 26'd1;
          end
        end
        S_PAUSED: begin
          if (Start && !Pause) begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          count_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= S_IDLE;
      count_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign Q       = count_q;
  assign Tick    = tick_q;
  assign Running = (state_q == S_RUN);
  assign Done    = (state_q == S_DONE);

endmodule

// File: tb/tb_countdown_8bits.sv
// Directed bench for countdown_8bits with PRESCALE=4; expected values are hand-derived.
module tb_countdown_8bits;

  logic       Clk = 1'b0;
  logic       Clr = 1'b1;
  logic       Load = 1'b0;
  logic [7:0] D = '0;
  logic       Start = 1'b0;
  logic       Pause = 1'b0;
  logic [7:0] Q;
  logic       Tick;
  logic       Running;
  logic       Done;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned ticks = 0;

  countdown_8bits #(.PRESCALE(4)) dut (
    .Clk(Clk), .Clr(Clr), .Load(Load), .D(D), .Start(Start), .Pause(Pause),
    .Q(Q), .Tick(Tick), .Running(Running), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] q, input logic t,
                         input logic r, input logic d);
    chk({tag, ".Q"}, Q, q);
    chk({tag, ".Tick"}, {7'd0, Tick}, {7'd0, t});
    chk({tag, ".Running"}, {7'd0, Running}, {7'd0, r});
    chk({tag, ".Done"}, {7'd0, Done}, {7'd0, d});
  endtask

  initial begin
    // reset
    cyc();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    Clr = 1'b0;

    // basic countdown from 3
    Load = 1'b1; D = 8'h03;
    cyc();
    Load = 1'b0;
    chk_all("load3", 8'h03, 1'b0, 1'b0, 1'b0);
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    chk_all("start3", 8'h03, 1'b0, 1'b1, 1'b0);
    ticks = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (Tick === 1'b1) ticks++;
      chk("run3.Q", Q, 8'(3 - i / 4));
      chk("run3.Tick", {7'd0, Tick}, {7'd0, (i % 4) == 0});
      chk("run3.Running", {7'd0, Running}, {7'd0, i < 12});
    end
    chk_all("done3", 8'h00, 1'b1, 1'b0, 1'b1);
    cyc();
    chk_all("done3_hold", 8'h00, 1'b0, 1'b0, 1'b1);
    chk("tick_count3", 8'(ticks), 8'd3);

    // Start/Pause ignored in DONE
    Start = 1'b1; Pause = 1'b1;
    cyc();
    Pause = 1'b0;
    cyc();
    Start = 1'b0;
    chk_all("done_ignore", 8'h00, 1'b0, 1'b0, 1'b1);

    // pause at prescaler=2 for 10 cycles, then resume
    Load = 1'b1; D = 8'h05;
    cyc();
    Load = 1'b0;
    chk_all("load5", 8'h05, 1'b0, 1'b0, 1'b0);
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    cyc();
    cyc();
    chk_all("pre_pause", 8'h05, 1'b0, 1'b1, 1'b0);
    Pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk_all("paused", 8'h05, 1'b0, 1'b0, 1'b0);
    end
    Pause = 1'b0; Start = 1'b1;
    cyc();
    Start = 1'b0;
    chk_all("resume", 8'h05, 1'b0, 1'b1, 1'b0);
    cyc();
    chk_all("resume+1", 8'h05, 1'b0, 1'b1, 1'b0);
    cyc();
    chk_all("resume+2", 8'h04, 1'b1, 1'b1, 1'b0);
    for (int j = 1; j <= 16; j++) begin
      cyc();
      chk("run5.Q", Q, 8'(4 - j / 4));
      chk("run5.Tick", {7'd0, Tick}, {7'd0, (j % 4) == 0});
    end
    chk_all("done5", 8'h00, 1'b1, 1'b0, 1'b1);

    // load zero then start goes straight to DONE
    Load = 1'b1; D = 8'h00;
    cyc();
    Load = 1'b0;
    chk_all("load0", 8'h00, 1'b0, 1'b0, 1'b0);
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    chk_all("start0", 8'h00, 1'b0, 1'b0, 1'b1);
    cyc();
    chk_all("start0_hold", 8'h00, 1'b0, 1'b0, 1'b1);

    // Load mid-RUN at Q=1, prescaler=3
    Load = 1'b1; D = 8'h02;
    cyc();
    Load = 1'b0;
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    chk_all("q1_p3", 8'h01, 1'b0, 1'b1, 1'b0);
    Load = 1'b1; D = 8'h10;
    cyc();
    Load = 1'b0;
    chk_all("load_midrun", 8'h10, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_all("idle_hold", 8'h10, 1'b0, 1'b0, 1'b0);

    // Start+Pause together in RUN at prescaler==PRESCALE-1 -> PAUSED, no Tick
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    cyc(); cyc(); cyc();
    Start = 1'b1; Pause = 1'b1;
    cyc();
    chk_all("start_pause", 8'h10, 1'b0, 1'b0, 1'b0);
    Pause = 1'b0;
    cyc();
    Start = 1'b0;
    chk_all("resume_p3", 8'h10, 1'b0, 1'b1, 1'b0);
    cyc();
    chk_all("dec_after_resume", 8'h0F, 1'b1, 1'b1, 1'b0);

    // Clr during RUN at prescaler=3
    cyc(); cyc(); cyc();
    chk_all("pre_clr", 8'h0F, 1'b0, 1'b1, 1'b0);
    Clr = 1'b1;
    cyc();
    Clr = 1'b0;
    chk_all("clr_run", 8'h00, 1'b0, 1'b0, 1'b0);

    // Clr outranks Load
    Clr = 1'b1; Load = 1'b1; D = 8'hAA; Start = 1'b1;
    cyc();
    Clr = 1'b0; Load = 1'b0; Start = 1'b0;
    chk_all("clr_prio", 8'h00, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
